sd_bd_queue: RTL and testbench
==============================

# sd_bd_queue

Buffer-descriptor queue for one direction (TX or RX) of the SD data path; two instances are built, one per direction. The register/bus side pushes descriptors as two 32-bit words (system address, then card block argument). The SD data master pulls each descriptor with a per-word read/acknowledge handshake and releases the slot when the transfer completes. The free-slot count is exported so the master can see pending work and the interrupt logic can detect an emptied queue.

## Interface

Parameters:
- `BD_DEPTH`, 8 — descriptor slots; power of two, 2..128.
- `PTR_W`, 3 — log2(`BD_DEPTH`).

Ports:
- `clk`  in  1  — single clock.
- `rst`  in  1  — synchronous, active-high reset.
- `we_i`  in  1  — bus write strobe, one word per cycle.
- `dat_i`  in  32  — bus write data.
- `wr_err`  out  1  — one-cycle pulse: a write was dropped because the queue was full.
- `re_i`  in  1  — master read request, level.
- `ack_o`  out  1  — one-cycle word acknowledge to the master.
- `dat_o`  out  32  — descriptor word, valid while `ack_o`=1.
- `a_cmp_i`  in  1  — master transfer-complete, level; may be held for many cycles.
- `free_bd`  out  8  — count of free slots, 0..`BD_DEPTH`.
- `bd_clr`  in  1  — queue flush; only active with `SD_BD_CLR_EN`.

## Operation

- Storage: `BD_DEPTH` × 2 words (sys_adr, cmd_arg); write pointer `wp`, read pointer `rp`, each `PTR_W` bits, wrapping modulo `BD_DEPTH`.
- Write side:
  - Toggle `wsel`: first `we_i` stores sys_adr into slot `wp`, second stores cmd_arg.
  - Commit on the second word: `wp`+1, `free_bd`−1.
  - If `free_bd`==0 when the first word arrives, the pair is discarded; `wr_err` pulses on each discarded word.
- Fetchable entry: `used` = `BD_DEPTH` − `free_bd`, minus 1 while in `HOLD`; a fetch starts only when this is > 0.
- Read FSM:
  - `IDLE`: if `re_i` and an entry is fetchable → `W0`.
  - `W0`: `ack_o`=1, `dat_o`=sys_adr[`rp`] → `W1`.
  - `W1`: if `re_i`, next cycle `ack_o`=1, `dat_o`=cmd_arg[`rp`] → `HOLD`. If `re_i` is low, wait in `W1`.
  - `HOLD`: ignore `re_i`. On the rising edge of `a_cmp_i` (registered `a_cmp_q`): `rp`+1, `free_bd`+1 → `IDLE`.
- A held-high `a_cmp_i` releases exactly one slot. A rising edge outside `HOLD` is ignored.
- Commit and release in the same cycle: `free_bd` is unchanged; both pointers advance.
- `free_bd` never exceeds `BD_DEPTH` and never goes below 0.

## Timing

- Reset values: `ack_o`=0, `dat_o`=0, `wr_err`=0, `free_bd`=`BD_DEPTH`, `wp`=`rp`=0, `wsel`=0, FSM=`IDLE`, `a_cmp_q`=0. Storage is not cleared.
- Reset mid-operation drops any half-written pair, in-flight fetch and held entry.
- Read latency: `re_i` high in cycle N (entry fetchable, `IDLE`) → `ack_o` in N+1 (word0) and N+2 (word1) if `re_i` stays high through N+1.
- `ack_o` is never high two cycles for the same word. `dat_o` holds its last value when `ack_o`=0.
- `free_bd` updates in the cycle after the committing write or the `a_cmp_i` rising edge.
- Write to a slot while it is in `HOLD` is impossible by construction: a full queue rejects the write.

## Configuration

- `SD_BD_CLR_EN` defined: `bd_clr`=1 in any cycle forces reset values on every state except storage, taking effect the next cycle. A simultaneous `we_i` in that cycle is dropped. `bd_clr` has priority over `a_cmp_i` and `re_i`.
- `SD_BD_CLR_EN` undefined: the `bd_clr` port exists but is ignored; only `rst` clears the queue.

## Test plan

- After reset, `free_bd`=8. Write 0x0000_1000 then 0x0000_0020 → `free_bd`=7 after the second write. Assert `re_i` → `ack_o` with 0x0000_1000, then next cycle 0x0000_0020. FSM reaches `HOLD`.
- Hold `a_cmp_i` high for 5 cycles → `free_bd` returns to 8 exactly once. `re_i` re-asserted with the queue empty → no `ack_o`.
- Write 8 pairs, then a 9th → `free_bd`=0, two `wr_err` pulses, slot 0 unchanged. Fetch and complete all 8 in order → `rp` wraps to 0 and the data matches the order written.
- Commit the 2nd descriptor in the same cycle as the `a_cmp_i` rising edge for the 1st → `free_bd` stays 7.
- Drop `re_i` between word0 and word1 → FSM waits in `W1`. Re-assert → word1 acked one cycle later.
- With `SD_BD_CLR_EN`: fill 3 entries, fetch one, pulse `bd_clr` → `free_bd`=8, `IDLE`, no `ack_o`. Without the macro, the same stimulus leaves `free_bd`=5.

Source files
------------

// File: rtl/sd_bd_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sd_bd_queue : SD data-path buffer-descriptor queue, one direction (TX/RX).
// Optional flush input enabled by SD_BD_CLR_EN.            Revision: 1.0
// ---------------------------------------------------------------------------
module sd_bd_queue #(
  parameter int BD_DEPTH = 8,
  parameter int PTR_W    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] dat_i,
  output logic        wr_err,
  input  logic        re_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  input  logic        a_cmp_i,
  output logic [7:0]  free_bd,
  input  logic        bd_clr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_W0   = 2'd1;
  localparam logic [1:0] S_W1   = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;
  localparam logic [7:0] C_DEPTH = 8'(BD_DEPTH);

  logic [31:0]      r_sys_adr [BD_DEPTH];
  logic [31:0]      r_cmd_arg [BD_DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic             r_wsel;
  logic             r_drop;
  logic             r_a_cmp_q;
  logic [1:0]       r_state;
  logic [7:0]       r_free;

  logic       w_clr;
  logic       w_full;
  logic       w_hold;
  logic       w_store0;
  logic       w_store1;
  logic       w_release;
  logic [7:0] w_used;
  logic       w_fetch_ok;

`ifdef SD_BD_CLR_EN
  assign w_clr = bd_clr;
`else
  logic w_unused_bd_clr;
  assign w_unused_bd_clr = bd_clr;
  assign w_clr = 1'b0;
`endif

  // The drop decision is taken on the first word and carried to the second.
  assign w_full     = (r_free == 8'd0);
  assign w_hold     = (r_state == S_HOLD);
  assign w_store0   = we_i && !w_clr && !r_wsel && !w_full;
  assign w_store1   = we_i && !w_clr && r_wsel && !r_drop;
  assign w_release  = w_hold && a_cmp_i && !r_a_cmp_q;
  assign w_used     = C_DEPTH - r_free - {7'd0, w_hold};
  assign w_fetch_ok = (w_used != 8'd0);
  assign free_bd    = r_free;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_store0) r_sys_adr[r_wp] <= dat_i;
      if (w_store1) r_cmd_arg[r_wp] <= dat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_wsel    <= 1'b0;
      r_drop    <= 1'b0;
      r_a_cmp_q <= 1'b0;
      r_state   <= S_IDLE;
      r_free    <= C_DEPTH;
      wr_err    <= 1'b0;
      ack_o     <= 1'b0;
      dat_o     <= 32'd0;
    end else begin
      r_a_cmp_q <= a_cmp_i;
      wr_err    <= 1'b0;
      ack_o     <= 1'b0;

      if (we_i) begin
        r_wsel <= ~r_wsel;
        if (!r_wsel) begin
          r_drop <= w_full;
          wr_err <= w_full;
        end else begin
          wr_err <= r_drop;
        end
      end

      if (w_store1)  r_wp <= r_wp + PTR_W'(1);
      if (w_release) r_rp <= r_rp + PTR_W'(1);

      case ({w_store1, w_release})
        2'b10:   r_free <= r_free - 8'd1;
        2'b01:   r_free <= r_free + 8'd1;
        default: r_free <= r_free;
      endcase

      // W0 and W1 share the word-1 handoff so word1 can follow word0 back to back.
      case (r_state)
        S_IDLE: begin
          if (re_i && w_fetch_ok) begin
            r_state <= S_W0;
            ack_o   <= 1'b1;
            dat_o   <= r_sys_adr[r_rp];
          end
        end
        S_W0, S_W1: begin
          if (re_i) begin
            r_state <= S_HOLD;
            ack_o   <= 1'b1;
            dat_o   <= r_cmd_arg[r_rp];
          end else begin
            r_state <= S_W1;
          end
        end
        S_HOLD: begin
          if (w_release) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_bd_queue.sv
`default_nettype none
// tb_sd_bd_queue : directed stimulus against a queue-of-descriptors reference model,
// compared every cycle, plus hand-computed literal expectations.
module tb_sd_bd_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [31:0] dat_i;
  logic        wr_err;
  logic        re_i;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        a_cmp_i;
  logic [7:0]  free_bd;
  logic        bd_clr;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  sd_bd_queue #(.BD_DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we_i),
    .dat_i   (dat_i),
    .wr_err  (wr_err),
    .re_i    (re_i),
    .ack_o   (ack_o),
    .dat_o   (dat_o),
    .a_cmp_i (a_cmp_i),
    .free_bd (free_bd),
    .bd_clr  (bd_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: committed descriptors in a queue, head fetched word by word.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } desc_t;

  desc_t       q[$];
  int          words_out = 0;
  bit          half_open = 1'b0;
  bit          half_drop = 1'b0;
  bit          prev_cmp  = 1'b0;
  logic [31:0] half_word = '0;
  logic        exp_ack   = 1'b0;
  logic        exp_werr  = 1'b0;
  logic [31:0] exp_dat   = '0;

  always @(posedge clk) begin : model
    bit clr;
    bit rel;
    int free_now;
    clr = rst;
`ifdef SD_BD_CLR_EN
    clr = clr || bd_clr;
`endif
    if (clr) begin
      q.delete();
      words_out = 0;
      half_open = 1'b0;
      half_drop = 1'b0;
      prev_cmp  = 1'b0;
      exp_ack   = 1'b0;
      exp_werr  = 1'b0;
      exp_dat   = '0;
    end else begin
      free_now = DEPTH - q.size();
      rel      = (words_out == 2) && a_cmp_i && !prev_cmp;
      exp_ack  = 1'b0;
      exp_werr = 1'b0;
      if (words_out < 2 && re_i && (words_out > 0 || q.size() > 0)) begin
        exp_ack = 1'b1;
        exp_dat = (words_out == 0) ? q[0].a : q[0].b;
        words_out++;
      end
      if (rel) begin
        void'(q.pop_front());
        words_out = 0;
      end
      if (we_i) begin
        if (!half_open) begin
          half_drop = (free_now == 0);
          if (half_drop) exp_werr = 1'b1;
          else half_word = dat_i;
          half_open = 1'b1;
        end else begin
          if (half_drop) exp_werr = 1'b1;
          else q.push_back({half_word, dat_i});
          half_open = 1'b0;
        end
      end
      prev_cmp = a_cmp_i;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("ack_o", 32'(ack_o), 32'(exp_ack));
      check("wr_err", 32'(wr_err), 32'(exp_werr));
      check("dat_o", dat_o, exp_dat);
      check("free_bd", 32'(free_bd), 32'(DEPTH - q.size()));
    end
  end

  task automatic write_pair(input logic [31:0] a, input logic [31:0] b, output int errs);
    errs = 0;
    @(negedge clk); we_i = 1'b1; dat_i = a;
    @(negedge clk); if (wr_err) errs++; dat_i = b;
    @(negedge clk); if (wr_err) errs++; we_i = 1'b0;
  endtask

  task automatic fetch(output logic [31:0] w0, output logic [31:0] w1);
    int n;
    n  = 0;
    w0 = '0;
    w1 = '0;
    @(negedge clk); re_i = 1'b1;
    for (int i = 0; i < 12 && n < 2; i++) begin
      @(negedge clk);
      if (ack_o) begin
        if (n == 0) w0 = dat_o;
        else w1 = dat_o;
        n++;
      end
    end
    re_i = 1'b0;
    check("fetch_word_count", 32'(n), 32'd2);
  endtask

  task automatic complete(input int cycles);
    @(negedge clk); a_cmp_i = 1'b1;
    repeat (cycles) @(negedge clk);
    a_cmp_i = 1'b0;
  endtask

  task automatic count_acks(input int cycles, output int acks);
    acks = 0;
    @(negedge clk); re_i = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      if (ack_o) acks++;
    end
    re_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] w0, w1;
    int errs, tot, acks;
    rst = 1'b1; we_i = 1'b0; dat_i = '0; re_i = 1'b0; a_cmp_i = 1'b0; bd_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    check("reset_free_bd", 32'(free_bd), 32'd8);
    check("reset_ack", 32'(ack_o), 32'd0);
    check("reset_dat", dat_o, 32'd0);
    check("reset_wr_err", 32'(wr_err), 32'd0);

    // Basic write / fetch / complete
    write_pair(32'h0000_1000, 32'h0000_0020, errs);
    check("first_pair_free", 32'(free_bd), 32'd7);
    fetch(w0, w1);
    check("first_word0", w0, 32'h0000_1000);
    check("first_word1", w1, 32'h0000_0020);
    complete(5);
    @(negedge clk);
    check("held_cmp_free", 32'(free_bd), 32'd8);
    count_acks(4, acks);
    check("empty_no_ack", 32'(acks), 32'd0);

    // Fill to full, overflow pair, drain in order
    tot = 0;
    for (int i = 0; i < 8; i++) begin
      write_pair(32'h1000_0000 + 32'(i * 16), 32'h2000_0000 + 32'(i), errs);
      tot += errs;
    end
    check("fill_no_err", 32'(tot), 32'd0);
    write_pair(32'hDEAD_BEEF, 32'hBAD0_0000, errs);
    check("overflow_err_pulses", 32'(errs), 32'd2);
    check("full_free", 32'(free_bd), 32'd0);
    for (int i = 0; i < 8; i++) begin
      fetch(w0, w1);
      check("drain_word0", w0, 32'h1000_0000 + 32'(i * 16));
      check("drain_word1", w1, 32'h2000_0000 + 32'(i));
      complete(2);
    end
    @(negedge clk);
    check("drained_free", 32'(free_bd), 32'd8);

    // Commit of a second descriptor coincides with release of the first
    write_pair(32'hA000_0000, 32'hA000_0001, errs);
    fetch(w0, w1);
    check("wrap_word0", w0, 32'hA000_0000);
    @(negedge clk); we_i = 1'b1; dat_i = 32'hB000_0000;
    @(negedge clk); dat_i = 32'hB000_0001; a_cmp_i = 1'b1;
    @(negedge clk); we_i = 1'b0;
    check("same_cycle_free", 32'(free_bd), 32'd7);
    @(negedge clk); a_cmp_i = 1'b0;
    fetch(w0, w1);
    check("same_cycle_word0", w0, 32'hB000_0000);
    check("same_cycle_word1", w1, 32'hB000_0001);
    complete(2);

    // re_i dropped between word0 and word1
    write_pair(32'hC000_0000, 32'hC000_0001, errs);
    @(negedge clk); re_i = 1'b1;
    @(negedge clk);
    check("gap_ack0", 32'(ack_o), 32'd1);
    check("gap_dat0", dat_o, 32'hC000_0000);
    re_i = 1'b0;
    @(negedge clk);
    check("gap_wait1", 32'(ack_o), 32'd0);
    @(negedge clk);
    check("gap_wait2", 32'(ack_o), 32'd0);
    re_i = 1'b1;
    @(negedge clk);
    check("gap_ack1", 32'(ack_o), 32'd1);
    check("gap_dat1", dat_o, 32'hC000_0001);
    re_i = 1'b0;
    complete(2);

    // Flush with three entries, one in HOLD
    write_pair(32'hD000_0000, 32'hD000_0001, errs);
    write_pair(32'hE000_0000, 32'hE000_0001, errs);
    write_pair(32'hF000_0000, 32'hF000_0001, errs);
    fetch(w0, w1);
    @(negedge clk); bd_clr = 1'b1;
    @(negedge clk); bd_clr = 1'b0;
`ifdef SD_BD_CLR_EN
    check("clr_free", 32'(free_bd), 32'd8);
`else
    check("clr_free", 32'(free_bd), 32'd5);
`endif
    count_acks(4, acks);
    check("clr_no_ack", 32'(acks), 32'd0);
    complete(2);

    // Reset in the middle of a half-written pair
    @(negedge clk); we_i = 1'b1; dat_i = 32'h5555_0000;
    @(negedge clk); we_i = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("midreset_free", 32'(free_bd), 32'd8);
    write_pair(32'h6666_0000, 32'h6666_0001, errs);
    fetch(w0, w1);
    check("midreset_word0", w0, 32'h6666_0000);
    check("midreset_word1", w1, 32'h6666_0001);
    complete(2);

    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
